// File: rtl/tick_rate_meter.sv
// Measures the half-period of an asynchronous toggle, recovers the divider rate, reports lock/timeout.
// Define TICK_METER_GLITCH_FILTER_EN to reject input pulses shorter than FILTER_LEN cycles.
module tick_rate_meter #(
    parameter logic [31:0] FAST_HALF   = 32'd250001,
    parameter logic [31:0] SLOW_HALF   = 32'd25000001,
    parameter logic [31:0] TOL         = 32'd16,
    parameter logic [31:0] TIMEOUT_CYC = 32'd60000000,
    parameter int          FILTER_LEN  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_in,
    output logic [31:0] period_out,
    output logic        period_valid,
    output logic [1:0]  rate_code,
    output logic        locked,
    output logic        timeout
);

    localparam logic [1:0] RATE_UNKNOWN = 2'b00;
    localparam logic [1:0] RATE_SLOW    = 2'b01;
    localparam logic [1:0] RATE_FAST    = 2'b10;

    // Windows are 33 bits wide so X-TOL and X+TOL never wrap.
    localparam logic [32:0] FAST_LO = (FAST_HALF > TOL) ? {1'b0, FAST_HALF - TOL} : 33'd0;
    localparam logic [32:0] FAST_HI = {1'b0, FAST_HALF} + {1'b0, TOL};
    localparam logic [32:0] SLOW_LO = (SLOW_HALF > TOL) ? {1'b0, SLOW_HALF - TOL} : 33'd0;
    localparam logic [32:0] SLOW_HI = {1'b0, SLOW_HALF} + {1'b0, TOL};

    if (FILTER_LEN < 1) begin : g_bad_filter_len
        $error("tick_rate_meter: FILTER_LEN must be at least 1");
    end
    if ({1'b0, TIMEOUT_CYC} <= SLOW_HI) begin : g_bad_timeout
        $error("tick_rate_meter: TIMEOUT_CYC must exceed SLOW_HALF+TOL");
    end

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    logic        r_s1;
    logic        r_s2;
    logic        r_s3;
    logic        w_stable;
    logic        w_edge;
    logic [1:0]  w_class;
    logic [32:0] w_cnt_ext;

    state_t      r_state;
    logic [31:0] r_cnt;
    logic [31:0] r_period;
    logic        r_valid;
    logic [1:0]  r_rate;
    logic        r_locked;
    logic        r_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= tick_in;
            r_s2 <= r_s1;
        end
    end

`ifdef TICK_METER_GLITCH_FILTER_EN
    localparam int FCW = $clog2(FILTER_LEN + 1);

    logic [FCW-1:0] r_flt_cnt;
    logic           r_flt;

    // r_flt only follows s2 once s2 has differed from it for FILTER_LEN cycles in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flt_cnt <= '0;
            r_flt     <= 1'b0;
        end else if (r_s2 == r_flt) begin
            r_flt_cnt <= '0;
        end else if (r_flt_cnt == FCW'(FILTER_LEN - 1)) begin
            r_flt     <= r_s2;
            r_flt_cnt <= '0;
        end else begin
            r_flt_cnt <= r_flt_cnt + FCW'(1);
        end
    end

    assign w_stable = r_flt;
`else
    assign w_stable = r_s2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s3 <= 1'b0;
        end else begin
            r_s3 <= w_stable;
        end
    end

    assign w_edge    = w_stable ^ r_s3;
    assign w_cnt_ext = {1'b0, r_cnt};

    always_comb begin
        w_class = RATE_UNKNOWN;
        if (w_cnt_ext >= FAST_LO && w_cnt_ext <= FAST_HI) begin
            w_class = RATE_FAST;
        end else if (w_cnt_ext >= SLOW_LO && w_cnt_ext <= SLOW_HI) begin
            w_class = RATE_SLOW;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_period  <= '0;
            r_valid   <= 1'b0;
            r_rate    <= RATE_UNKNOWN;
            r_locked  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_edge) begin
                r_cnt <= 32'd1;
            end else if (r_cnt != 32'hFFFF_FFFF) begin
                r_cnt <= r_cnt + 32'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_edge) begin
                        r_state   <= ST_MEASURE;
                        r_timeout <= 1'b0;
                    end
                end
                ST_MEASURE: begin
                    // r_rate doubles as the previous class for the lock decision.
                    if (w_edge) begin
                        r_period <= r_cnt;
                        r_valid  <= 1'b1;
                        r_rate   <= w_class;
                        r_locked <= (w_class != RATE_UNKNOWN) && (w_class == r_rate);
                    end else if (r_cnt == TIMEOUT_CYC) begin
                        r_timeout <= 1'b1;
                        r_locked  <= 1'b0;
                        r_rate    <= RATE_UNKNOWN;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign period_out   = r_period;
    assign period_valid = r_valid;
    assign rate_code    = r_rate;
    assign locked       = r_locked;
    assign timeout      = r_timeout;

endmodule

// File: tb/tb_tick_rate_meter.sv
// Self-checking bench for tick_rate_meter: toggle gaps are fed to a gap-based reference model and
// the reports captured from period_valid are compared against it.
module tb_tick_rate_meter;

    localparam int FAST = 10;
    localparam int SLOW = 100;
    localparam int TOLR = 2;
    localparam int TMO  = 300;
    localparam int FLEN = 4;
`ifdef TICK_METER_GLITCH_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif
    localparam int LAT = 3 + (FILT ? FLEN : 0);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_in = 1'b0;
    logic [31:0] period_out;
    logic        period_valid;
    logic [1:0]  rate_code;
    logic        locked;
    logic        timeout;

    tick_rate_meter #(
        .FAST_HALF  (32'd10),
        .SLOW_HALF  (32'd100),
        .TOL        (32'd2),
        .TIMEOUT_CYC(32'd300),
        .FILTER_LEN (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_in     (tick_in),
        .period_out  (period_out),
        .period_valid(period_valid),
        .rate_code   (rate_code),
        .locked      (locked),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct packed {
        logic [31:0] p;
        logic [1:0]  c;
        logic        l;
    } rpt_t;

    rpt_t obs_q[$];
    rpt_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always @(negedge clk) begin
        if (rst_n && period_valid) obs_q.push_back({period_out, rate_code, locked});
    end

    // Reference model: works purely on the gaps between input toggles.
    bit          m_armed;
    int          m_last;
    logic [1:0]  m_class;
    logic        m_locked;
    logic [31:0] m_period;
    logic        m_tmo;

    function automatic logic [1:0] classify(input int p);
        int df_f = (p > FAST) ? p - FAST : FAST - p;
        int df_s = (p > SLOW) ? p - SLOW : SLOW - p;
        if (df_f <= TOLR) return 2'b10;
        if (df_s <= TOLR) return 2'b01;
        return 2'b00;
    endfunction

    function automatic void model_reset();
        m_armed = 1'b0; m_class = 2'b00; m_locked = 1'b0;
        m_period = '0; m_tmo = 1'b0; m_last = cyc;
        obs_q.delete(); exp_q.delete();
    endfunction

    function automatic void apply_timeout();
        m_armed = 1'b0; m_class = 2'b00; m_locked = 1'b0; m_tmo = 1'b1;
    endfunction

    // Bring the model's timeout state up to date for a level check taken now.
    function automatic void model_sync(input int now);
        if (m_armed && (now - m_last) >= TMO + LAT) apply_timeout();
    endfunction

    function automatic void model_edge(input int now);
        int   gap = now - m_last;
        rpt_t r;
        m_last = now;
        if (m_armed && gap > TMO) apply_timeout();
        if (!m_armed) begin
            m_armed = 1'b1;
            m_tmo   = 1'b0;
        end else begin
            r.p = 32'(gap);
            r.c = classify(gap);
            r.l = (r.c != 2'b00) && (r.c == m_class);
            m_class = r.c; m_locked = r.l; m_period = r.p;
            exp_q.push_back(r);
        end
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic toggle_edge();
        tick_in = ~tick_in;
        model_edge(cyc);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tick_in = 1'b0;
        wait_cyc(3);
        checks++;
        if (period_out !== 32'd0) begin
            errors++; $display("FAIL reset_period: got %0d expected 0", period_out);
        end
        checks++;
        if ({period_valid, rate_code, locked, timeout} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got v=%b c=%b l=%b t=%b expected all 0", period_valid, rate_code, locked, timeout);
        end
        rst_n = 1'b1;
        model_reset();
        wait_cyc(2);
    endtask

    task automatic test_fast();
        rpt_t o, x;
        for (int i = 0; i < 6; i++) begin
            toggle_edge();
            wait_cyc(FAST);
        end
        wait_cyc(12);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL fast_count: got %0d reports expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); x = exp_q.pop_front(); checks++;
            if (o !== x) begin
                errors++; $display("FAIL fast_report: got p=%0d c=%b l=%b expected p=%0d c=%b l=%b", o.p, o.c, o.l, x.p, x.c, x.l);
            end
        end
        obs_q.delete(); exp_q.delete();
        model_sync(cyc); checks++;
        if ({rate_code, locked, timeout, period_out} !== {m_class, m_locked, m_tmo, m_period} || rate_code !== 2'b10) begin
            errors++; $display("FAIL fast_levels: got c=%b l=%b t=%b p=%0d expected c=%b l=%b t=%b p=%0d", rate_code, locked, timeout, period_out, m_class, m_locked, m_tmo, m_period);
        end
    endtask

    task automatic test_slow_switch();
        rpt_t o, x;
        for (int i = 0; i < 4; i++) begin
            toggle_edge();
            wait_cyc(SLOW);
        end
        for (int i = 0; i < 3; i++) begin
            toggle_edge();
            wait_cyc(11);
        end
        toggle_edge();
        wait_cyc(12);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL switch_count: got %0d reports expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); x = exp_q.pop_front(); checks++;
            if (o !== x) begin
                errors++; $display("FAIL switch_report: got p=%0d c=%b l=%b expected p=%0d c=%b l=%b", o.p, o.c, o.l, x.p, x.c, x.l);
            end
        end
        obs_q.delete(); exp_q.delete();
        model_sync(cyc); checks++;
        if ({rate_code, locked, period_out} !== {m_class, m_locked, m_period}) begin
            errors++; $display("FAIL switch_levels: got c=%b l=%b p=%0d expected c=%b l=%b p=%0d", rate_code, locked, period_out, m_class, m_locked, m_period);
        end
    endtask

    task automatic test_unknown();
        rpt_t o, x;
        for (int i = 0; i < 4; i++) begin
            toggle_edge();
            wait_cyc(50);
        end
        toggle_edge();
        wait_cyc(12);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL unknown_count: got %0d reports expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); x = exp_q.pop_front(); checks++;
            if (o !== x) begin
                errors++; $display("FAIL unknown_report: got p=%0d c=%b l=%b expected p=%0d c=%b l=%b", o.p, o.c, o.l, x.p, x.c, x.l);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_timeout();
        rpt_t o, x;
        int   n_before;
        toggle_edge(); wait_cyc(FAST);
        toggle_edge(); wait_cyc(FAST);
        toggle_edge(); wait_cyc(TMO);
        toggle_edge(); wait_cyc(TMO + 1);
        toggle_edge(); wait_cyc(TMO + 20);
        model_sync(cyc); checks++;
        if ({timeout, rate_code, locked} !== {m_tmo, m_class, m_locked} || timeout !== 1'b1) begin
            errors++; $display("FAIL timeout_set: got t=%b c=%b l=%b expected t=%b c=%b l=%b", timeout, rate_code, locked, m_tmo, m_class, m_locked);
        end
        n_before = obs_q.size();
        toggle_edge();
        wait_cyc(12);
        model_sync(cyc); checks++;
        if (timeout !== m_tmo || obs_q.size() != n_before) begin
            errors++; $display("FAIL timeout_clear: got t=%b new_reports=%0d expected t=%b new_reports=0", timeout, obs_q.size() - n_before, m_tmo);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL timeout_count: got %0d reports expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); x = exp_q.pop_front(); checks++;
            if (o !== x) begin
                errors++; $display("FAIL timeout_report: got p=%0d c=%b l=%b expected p=%0d c=%b l=%b", o.p, o.c, o.l, x.p, x.c, x.l);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        rpt_t o, x;
        for (int i = 0; i < 3; i++) begin
            toggle_edge();
            wait_cyc(SLOW);
        end
        toggle_edge();
        wait_cyc(42);
        obs_q.delete(); exp_q.delete();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({period_out, period_valid, rate_code, locked, timeout} !== 37'd0) begin
            errors++; $display("FAIL midreset_outputs: got p=%0d v=%b c=%b l=%b t=%b expected all 0", period_out, period_valid, rate_code, locked, timeout);
        end
        tick_in = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        model_reset();
        wait_cyc(2);
        for (int i = 0; i < 4; i++) begin
            toggle_edge();
            wait_cyc(FAST);
        end
        wait_cyc(12);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL midreset_count: got %0d reports expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); x = exp_q.pop_front(); checks++;
            if (o !== x) begin
                errors++; $display("FAIL midreset_report: got p=%0d c=%b l=%b expected p=%0d c=%b l=%b", o.p, o.c, o.l, x.p, x.c, x.l);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_glitch();
        rpt_t o, x;
        for (int k = 0; k < 4; k++) begin
            toggle_edge();
            wait_cyc(4);
            tick_in = ~tick_in;
            if (!FILT) model_edge(cyc);
            wait_cyc(2);
            tick_in = ~tick_in;
            if (!FILT) model_edge(cyc);
            wait_cyc(4);
        end
        toggle_edge();
        wait_cyc(12);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL glitch_count: got %0d reports expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); x = exp_q.pop_front(); checks++;
            if (o !== x) begin
                errors++; $display("FAIL glitch_report: got p=%0d c=%b l=%b expected p=%0d c=%b l=%b", o.p, o.c, o.l, x.p, x.c, x.l);
            end
        end
        obs_q.delete(); exp_q.delete();
        checks++;
        if (period_out !== m_period) begin
            errors++; $display("FAIL glitch_period: got %0d expected %0d", period_out, m_period);
        end
    endtask

    task automatic test_back_to_back();
        rpt_t o, x;
        int   gaps[7] = '{1, 1, 1, 1, 1, 2, 2};
        toggle_edge();
        foreach (gaps[i]) begin
            wait_cyc(gaps[i]);
            toggle_edge();
        end
        wait_cyc(12);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL b2b_count: got %0d reports expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); x = exp_q.pop_front(); checks++;
            if (o !== x) begin
                errors++; $display("FAIL b2b_report: got p=%0d c=%b l=%b expected p=%0d c=%b l=%b", o.p, o.c, o.l, x.p, x.c, x.l);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        rpt_t o, x;
        int   g;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0:       g = FAST - 4 + int'($urandom_range(0, 8));
                1:       g = SLOW - 4 + int'($urandom_range(0, 8));
                2:       g = int'($urandom_range(6, 250));
                3:       g = TMO - 2 + int'($urandom_range(0, 4));
                default: g = FAST;
            endcase
            if (g < 6) g = 6;
            wait_cyc(g);
            toggle_edge();
            if ((i % 10) == 9) begin
                wait_cyc(12);
                model_sync(cyc); checks++;
                if ({rate_code, locked, timeout, period_out} !== {m_class, m_locked, m_tmo, m_period}) begin
                    errors++; $display("FAIL random_levels: got c=%b l=%b t=%b p=%0d expected c=%b l=%b t=%b p=%0d", rate_code, locked, timeout, period_out, m_class, m_locked, m_tmo, m_period);
                end
            end
        end
        wait_cyc(12);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL random_count: got %0d reports expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); x = exp_q.pop_front(); checks++;
            if (o !== x) begin
                errors++; $display("FAIL random_report: got p=%0d c=%b l=%b expected p=%0d c=%b l=%b", o.p, o.c, o.l, x.p, x.c, x.l);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_fast();
        test_slow_switch();
        test_unknown();
        test_timeout();
        test_reset_mid();
        test_glitch();
`ifndef TICK_METER_GLITCH_FILTER_EN
        test_back_to_back();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
